// File: rtl/chunked_ripple_subtractor.sv
// ---------------------------------------------------------------------------
// chunked_ripple_subtractor
//
// Multi-cycle ripple-borrow subtractor. It computes d = a - b - bin over
// WIDTH bits and handles CHUNK bits per clock, starting with the LSB chunk.
// A single borrow flop carries the borrow from one chunk to the next.
// This block is the subtract-direction twin of the chunked ripple-carry adder.
// It trades latency (WIDTH/CHUNK cycles) for a narrow CHUNK-bit subtractor.
//
// Parameters:
//   WIDTH      operand/result width; must be a multiple of CHUNK
//   CHUNK      bits subtracted per cycle (1 <= CHUNK <= WIDTH)
//
// Ports:
//   clk        single clock, rising edge
//   reset      asynchronous, active-high reset
//   in_valid   operands a/b/bin presented
//   in_ready   block is idle and will accept operands
//   a, b, bin  minuend, subtrahend, borrow-in
//   out_valid  result d/bout is valid; held until out_ready
//   out_ready  consumer takes the result
//   d          difference, a - b - bin mod 2^WIDTH
//   bout       borrow-out, 1 iff a < b + bin (unsigned)
//   ovf        (only with SUB_OVF_EN) signed two's-complement overflow
//
// Optional feature: define SUB_OVF_EN to add the ovf output.
// ---------------------------------------------------------------------------
module chunked_ripple_subtractor #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout
`ifdef SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    // The counter needs at least one bit, even when NCHUNK is 1.
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             borrow;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   diff;
    logic             last;

    // The chunk subtractor is one CHUNK+1 bit subtraction. When the chunk
    // result is negative, the extra MSB is set, so that bit is the borrow
    // for the next chunk.
    // NOTE: give every always_comb output a value at the top of the block.
    // Then no path leaves a variable unassigned, and no latch is inferred.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        diff    = '0;
        last    = 1'b0;
        a_chunk = a_q[cnt*CHUNK +: CHUNK];
        b_chunk = b_q[cnt*CHUNK +: CHUNK];
        diff    = {1'b0, a_chunk} - {1'b0, b_chunk} - {{CHUNK{1'b0}}, borrow};
        last    = (cnt == CW'(NCHUNK - 1));
    end

    // NOTE: sequential state uses non-blocking assignments only. Each flop
    // then samples the value from before the edge, whatever order the
    // statements are in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the operand registers are reset too. An aborted
            // operation then leaves no stale operand data behind.
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            d         <= '0;
            bout      <= 1'b0;
            cnt       <= '0;
            borrow    <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
`ifdef SUB_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        borrow   <= bin;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end

                RUN: begin
                    d[cnt*CHUNK +: CHUNK] <= diff[CHUNK-1:0];
                    borrow                <= diff[CHUNK];
                    cnt                   <= cnt + 1'b1;
                    if (last) begin
                        bout      <= diff[CHUNK];
                        out_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= DONE;
`ifdef SUB_OVF_EN
                        // The sign bit of d is written on this same edge.
                        // Take it from the chunk result, not from the d
                        // register, which still holds the old value.
                        ovf <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                               (diff[CHUNK-1] != a_q[WIDTH-1]);
`endif
                    end
                end

                DONE: begin
                    // Hold the result for as long as the consumer stalls.
                    // Go back to IDLE one cycle before a new accept is
                    // possible.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_ripple_subtractor.sv
// ---------------------------------------------------------------------------
// Testbench for chunked_ripple_subtractor (WIDTH=32, CHUNK=8).
// It runs the directed cases from the test plan, then randomized operations.
// Each result is compared with a reference model that uses whole-word
// arithmetic.
// ---------------------------------------------------------------------------
module tb_chunked_ripple_subtractor;

    localparam int WIDTH  = 32;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d;
    logic             bout;
`ifdef SUB_OVF_EN
    logic             ovf;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    chunked_ripple_subtractor #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout)
`ifdef SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: whole-word arithmetic on the operands.
    task automatic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                         input logic mbin, output logic [WIDTH-1:0] ed,
                         output logic eb, output logic eo);
        logic [WIDTH:0] need;
        need = {1'b0, mb} + {{WIDTH{1'b0}}, mbin};
        eb   = ({1'b0, ma} < need);
        ed   = ma - mb - {{(WIDTH-1){1'b0}}, mbin};
        eo   = (ma[WIDTH-1] != mb[WIDTH-1]) && (ed[WIDTH-1] != ma[WIDTH-1]);
    endtask

    // Runs one operation and checks it.
    // hold: number of DONE cycles with out_ready low.
    // poke: drive in_valid with junk operands during the stall.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] ta,
                          input logic [WIDTH-1:0] tb, input logic tbin,
                          input int hold, input bit poke);
        logic [WIDTH-1:0] ed;
        logic             eb;
        logic             eo;
        logic [WIDTH:0]   ident;
        int               lat;
        model(ta, tb, tbin, ed, eb, eo);
        ident = {1'b0, ta} + {1'b0, ~tb} + {{WIDTH{1'b0}}, ~tbin};

        @(negedge clk);
        check({tag, "/in_ready_idle"}, in_ready, 1);
        a = ta; b = tb; bin = tbin; in_valid = 1'b1;
        @(posedge clk);  // accepting edge E0
        #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; bin = 1'(($urandom));
        check({tag, "/busy_after_accept"}, in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "/latency"}, lat, NCHUNK);
        check({tag, "/d"}, d, ed);
        check({tag, "/bout"}, bout, eb);
        check({tag, "/identity"}, {~bout, d}, ident);
`ifdef SUB_OVF_EN
        check({tag, "/ovf"}, ovf, eo);
`endif
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                in_valid = 1'b1;
                a = $urandom; b = $urandom; bin = 1'b1;
            end
            @(posedge clk);
            #1;
            check({tag, "/hold_valid"}, out_valid, 1);
            check({tag, "/hold_in_ready"}, in_ready, 0);
            check({tag, "/hold_d"}, d, ed);
            check({tag, "/hold_bout"}, bout, eb);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({tag, "/valid_dropped"}, out_valid, 0);
        check({tag, "/in_ready_back"}, in_ready, 1);
        check({tag, "/d_kept"}, d, ed);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; bin = 1'b0;
        #22;
        check("reset/in_ready", in_ready, 1);
        check("reset/out_valid", out_valid, 0);
        check("reset/d", d, 0);
        check("reset/bout", bout, 0);
`ifdef SUB_OVF_EN
        check("reset/ovf", ovf, 0);
`endif
        @(negedge clk);
        reset = 1'b0;

        // Directed cases
        run_op("t1_5m3",        32'h0000_0005, 32'h0000_0003, 1'b0, 0, 1'b0);
        run_op("t2_ripple",     32'h1000_0000, 32'h0000_0001, 1'b0, 0, 1'b0);
        run_op("t2_wrap",       32'h0000_0000, 32'h0000_0001, 1'b0, 0, 1'b0);
        run_op("t3_eq_bin1",    32'h1234_5678, 32'h1234_5678, 1'b1, 0, 1'b0);
        run_op("t3_eq_bin0",    32'h1234_5678, 32'h1234_5678, 1'b0, 0, 1'b0);
        run_op("t4_backpress",  32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 3, 1'b1);
        run_op("t4_second",     32'h0000_1000, 32'h0000_2000, 1'b0, 0, 1'b0);

        // Asynchronous reset after two chunks of a RUN
        @(negedge clk);
        a = 32'hFFFF_FFFF; b = 32'h1111_1111; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("t5/partial_low", d[15:0], 16'hEEEE);
        #1 reset = 1'b1;
        #1;
        check("t5/in_ready", in_ready, 1);
        check("t5/out_valid", out_valid, 0);
        check("t5/d", d, 0);
        check("t5/bout", bout, 0);
        @(negedge clk);
        reset = 1'b0;
        run_op("t5_after",      32'h0000_0064, 32'h0000_000A, 1'b0, 0, 1'b0);

`ifdef SUB_OVF_EN
        run_op("t6_neg_ovf",    32'h8000_0000, 32'h0000_0001, 1'b0, 0, 1'b0);
        check("t6/ovf1", ovf, 1);
        run_op("t6_pos_ovf",    32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
        check("t6/ovf2", ovf, 1);
        run_op("t6_no_ovf",     32'h0000_0005, 32'h0000_0003, 1'b0, 0, 1'b0);
        check("t6/ovf3", ovf, 0);
`endif

        // Randomized operations; every fourth one uses a == b
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = (i % 4 == 0) ? ra : $urandom;
            run_op("rand", ra, rb, 1'($urandom), int'($urandom_range(0, 2)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
